// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - Pattern-RAM note sequencer driving the tone generator.
//
// Plays a writable pattern RAM of note codes, one step every tempo_eff clocks,
// in loop or one-shot mode, and reports note changes to the tone generator.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data pattern RAM write port (synchronous)
//   start, stop             single-cycle control pulses; stop wins over start
//   loop                    1 = wrap at end of pattern, 0 = one-shot
//   play_len                steps to play, 0 = full depth 2**STEP_W
//   tempo                   clocks per step, 0 treated as 1
//   note                    current note code (REST_CODE = silence)
//   note_on                 one-cycle strobe on a change to a sounding note
//   step                    index of the step currently sounding
//   busy                    high while playing
//   done                    one-cycle strobe when a one-shot pattern ends
module note_sequencer #(
  parameter int NOTE_W    = 5,
  parameter int STEP_W    = 7,
  parameter int TEMPO_W   = 25,
  parameter int REST_CODE = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [STEP_W-1:0]  wr_addr,
  input  logic [NOTE_W-1:0]  wr_data,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [STEP_W-1:0]  play_len,
  input  logic [TEMPO_W-1:0] tempo,
  output logic [NOTE_W-1:0]  note,
  output logic               note_on,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 1 << STEP_W;
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_CODE);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t              state_q;
  logic [NOTE_W-1:0]   note_q;
  logic                note_on_q;
  logic [STEP_W-1:0]   step_q;
  logic                busy_q;
  logic                done_q;
  logic [TEMPO_W-1:0]  tick_q;

  logic [NOTE_W-1:0]   mem_q [0:DEPTH-1];

  logic [TEMPO_W-1:0]  tick_limit;
  logic                boundary;
  logic                last_step;
  logic [STEP_W-1:0]   step_d;
  logic [NOTE_W-1:0]   note_d;
  logic [NOTE_W-1:0]   first_note;
  logic                step_strobe;

  // Pattern RAM: no reset, asynchronous read so a write lands before the
  // next fetch edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    tick_limit  = (tempo == '0) ? '0 : tempo - TEMPO_W'(1);
    boundary    = (tick_q >= tick_limit);
    // play_len of 0 wraps to all-ones, i.e. the last step of the full depth.
    last_step   = (step_q == play_len - STEP_W'(1));
    step_d      = last_step ? '0 : step_q + STEP_W'(1);
    note_d      = mem_q[step_d];
    first_note  = mem_q[0];
    step_strobe = (note_d != REST) && ((note_d != note_q) || (note_q == REST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      note_q    <= REST;
      note_on_q <= 1'b0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tick_q    <= '0;
    end else begin
      note_on_q <= 1'b0;
      done_q    <= 1'b0;
      if (stop) begin
        // Abort from any state; harmless in IDLE.
        state_q <= IDLE;
        note_q  <= REST;
        step_q  <= '0;
        busy_q  <= 1'b0;
        tick_q  <= '0;
      end else if (start) begin
        // (Re)start always strobes a sounding first note, even if it
        // equals the note already playing.
        state_q   <= PLAY;
        note_q    <= first_note;
        note_on_q <= (first_note != REST);
        step_q    <= '0;
        busy_q    <= 1'b1;
        tick_q    <= '0;
      end else if (state_q == PLAY) begin
        if (boundary) begin
          tick_q <= '0;
          if (last_step && !loop) begin
            state_q <= IDLE;
            note_q  <= REST;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            step_q    <= step_d;
            note_q    <= note_d;
            note_on_q <= step_strobe;
          end
        end else begin
          tick_q <= tick_q + TEMPO_W'(1);
        end
      end
    end
  end

  assign note    = note_q;
  assign note_on = note_on_q;
  assign step    = step_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
